// File: rtl/mod_ctrl.sv
// Frame sequencer feeding the address-generator DMA: IDLE -> LOAD -> RUN -> DONE,
// with abort, completed-frame counting and a sticky start-while-busy flag.
module mod_ctrl #(
  parameter int ADDR_W = 10,
  parameter int FRM_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              clr_err,
  input  logic [ADDR_W-1:0] cfg_load_len,
  input  logic [ADDR_W-1:0] cfg_run_len,
  output logic [1:0]        state,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [FRM_W-1:0]  frame_cnt,
  output logic              err_start
);

  // Encoding doubles as the DMA state bus, so it must not be re-encoded.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_RUN  = 2'b10,
    S_DONE = 2'b11
  } st_e;

  st_e               st;
  logic [ADDR_W-1:0] ph_cnt;
  logic [ADDR_W-1:0] load_len_r;
  logic [ADDR_W-1:0] run_len_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= S_IDLE;
      ph_cnt     <= '0;
      load_len_r <= '0;
      run_len_r  <= '0;
      aborted    <= 1'b0;
      frame_cnt  <= '0;
      err_start  <= 1'b0;
    end else begin
      aborted <= 1'b0;
      // A new error outranks a clear in the same cycle.
      if (start && (st != S_IDLE))
        err_start <= 1'b1;
      else if (clr_err)
        err_start <= 1'b0;

      case (st)
        S_IDLE: begin
          if (start && !abort) begin
            st         <= S_LOAD;
            load_len_r <= cfg_load_len;
            run_len_r  <= cfg_run_len;
            ph_cnt     <= '0;
          end
        end
        S_LOAD: begin
          if (abort) begin
            st      <= S_IDLE;
            aborted <= 1'b1;
          end else if (ph_cnt == load_len_r) begin
            st     <= S_RUN;
            ph_cnt <= '0;
          end else begin
            ph_cnt <= ph_cnt + ADDR_W'(1);
          end
        end
        S_RUN: begin
          if (abort) begin
            st      <= S_IDLE;
            aborted <= 1'b1;
          end else if (ph_cnt == run_len_r) begin
            st        <= S_DONE;
            frame_cnt <= frame_cnt + FRM_W'(1);
          end else begin
            ph_cnt <= ph_cnt + ADDR_W'(1);
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

  assign state = st;
  assign busy  = (st != S_IDLE);
  assign done  = (st == S_DONE);

endmodule

// File: tb/tb_mod_ctrl.sv
// Scoreboard bench for mod_ctrl: expected per-cycle outputs are queued as
// stimulus is driven and compared one cycle at a time after each rising edge.
module tb_mod_ctrl;
  localparam int ADDR_W = 10;
  localparam int FRM_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start, abort, clr_err;
  logic [ADDR_W-1:0] cfg_load_len, cfg_run_len;
  logic [1:0]        state;
  logic              busy, done, aborted, err_start;
  logic [FRM_W-1:0]  frame_cnt;

  mod_ctrl #(.ADDR_W(ADDR_W), .FRM_W(FRM_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .clr_err(clr_err),
    .cfg_load_len(cfg_load_len), .cfg_run_len(cfg_run_len),
    .state(state), .busy(busy), .done(done), .aborted(aborted),
    .frame_cnt(frame_cnt), .err_start(err_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [13:0] v;
  } exp_t;

  exp_t             exp_q[$];
  int               n_cmp = 0;
  int               n_err = 0;
  logic [FRM_W-1:0] exp_fc;
  logic             exp_err;
  logic [1:0]       prev_st;

  // {state, busy, done, aborted, frame_cnt, err_start}
  function automatic logic [13:0] obs_vec();
    return {state, busy, done, aborted, frame_cnt, err_start};
  endfunction

  task automatic chk(input string tag, input logic [13:0] obs, input logic [13:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got st=%b bsy=%b dn=%b ab=%b fc=%0d err=%b, want st=%b bsy=%b dn=%b ab=%b fc=%0d err=%b",
               tag, obs[13:12], obs[11], obs[10], obs[9], obs[8:1], obs[0],
               exp[13:12], exp[11], exp[10], exp[9], exp[8:1], exp[0]);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.tag, obs_vec(), e.v);
    end
  end

  // Drive one cycle of inputs and queue what the outputs must be after the edge.
  task automatic cyc(input logic s, input logic a, input logic c,
                     input logic [ADDR_W-1:0] ll, input logic [ADDR_W-1:0] rl,
                     input logic [1:0] est, input logic eab, input string tag);
    exp_t e;
    @(negedge clk);
    start = s; abort = a; clr_err = c;
    cfg_load_len = ll; cfg_run_len = rl;
    if (s && prev_st != 2'b00) exp_err = 1'b1;
    else if (c)                exp_err = 1'b0;
    if (est == 2'b11) exp_fc = exp_fc + 1'b1;
    prev_st = est;
    e.tag = tag;
    e.v   = {est, est != 2'b00, est == 2'b11, eab, exp_fc, exp_err};
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input string tag);
    for (int k = 0; k < n; k++)
      cyc(1'b0, 1'b0, 1'b0, ADDR_W'($urandom), ADDR_W'($urandom), 2'b00, 1'b0, tag);
  endtask

  // One frame; index i is the edge count after the start edge. Edges 0..L are
  // LOAD, L+1..L+R+1 RUN, L+R+2 DONE, L+R+3 back in IDLE.
  task automatic frame(input int L, input int R, input int err_i, input int clr_i,
                       input int ab_i, input int stop);
    logic [1:0] est;
    logic       ab;
    cyc(1'b1, 1'b0, 1'b0, ADDR_W'(L), ADDR_W'(R), 2'b01, 1'b0,
        $sformatf("L%0d/R%0d start", L, R));
    for (int i = 1; i <= stop; i++) begin
      if (i <= L)              est = 2'b01;
      else if (i <= L + R + 1) est = 2'b10;
      else if (i == L + R + 2) est = 2'b11;
      else                     est = 2'b00;
      ab = (i == ab_i) && (i <= L + R + 2);
      if (ab) est = 2'b00;
      // cfg is scrambled mid-frame; only the start-edge values may matter
      cyc(i == err_i, i == ab_i, i == clr_i, ADDR_W'($urandom), ADDR_W'($urandom),
          est, ab, $sformatf("L%0d/R%0d e%0d", L, R, i));
      if (ab) break;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; clr_err = 1'b0;
    cfg_load_len = '0; cfg_run_len = '0;
    exp_fc = '0; exp_err = 1'b0; prev_st = 2'b00;
    #3;
    chk("reset_async", obs_vec(), 14'd0);
    start = 1'b1; abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_held", obs_vec(), 14'd0);
    @(negedge clk);
    start = 1'b0; rst = 1'b0;

    frame(3, 5, -1, -1, -1, 3 + 5 + 3);
    idle(2, "idle_a");
    frame(0, 0, -1, -1, -1, 3);
    idle(1, "idle_b");
    // start in 2nd LOAD cycle, then clr together with a busy start, then clr alone
    frame(4, 3, 2, -1, -1, 4 + 3 + 3);
    frame(2, 2, 1, 1, -1, 2 + 2 + 3);
    cyc(1'b0, 1'b0, 1'b1, '0, '0, 2'b00, 1'b0, "clr_alone");
    // abort on the 3rd RUN cycle
    frame(2, 5, -1, -1, 2 + 3, 2 + 5 + 3);
    idle(2, "post_abort");
    cyc(1'b1, 1'b1, 1'b0, 10'd1, 10'd1, 2'b00, 1'b0, "start_abort_idle");
    cyc(1'b0, 1'b1, 1'b0, 10'd1, 10'd1, 2'b00, 1'b0, "abort_idle");
    // start held through DONE flags an error, then restarts immediately
    frame(1, 1, 1 + 1 + 3, -1, -1, 1 + 1 + 3);
    frame(0, 1, -1, -1, -1, 0 + 1 + 3);
    cyc(1'b0, 1'b0, 1'b1, '0, '0, 2'b00, 1'b0, "clr2");
    frame(1023, 0, -1, -1, -1, 1023 + 0 + 3);
    for (int f = 0; f < 256; f++) frame(0, 0, -1, -1, -1, 3);
    idle(1, "post_wrap");
    frame(2, 6, -1, -1, -1, 5);
    drain();
    #1;
    rst = 1'b1;
    #1;
    chk("rst_midrun", obs_vec(), 14'd0);
    exp_fc = '0; exp_err = 1'b0; prev_st = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    idle(1, "post_rst");
    frame(0, 0, -1, -1, -1, 3);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
